// File: rtl/aggregator_pkg.sv
// Shared defaults for the aggregator/deaggregator pair and the lane-slice macro
// used by both to address lane k of a packed wide word.
`ifndef AGGREGATOR_PKG_LANE
`define AGGREGATOR_PKG_LANE
`define LANE(v, k) v[(k)*DATA_WIDTH +: DATA_WIDTH]
`endif

package aggregator_pkg;
  localparam int AGG_DATA_WIDTH  = 16;
  localparam int AGG_FETCH_WIDTH = 4;
endpackage

// File: rtl/aggregator.sv
// Packs narrow words into FETCH_WIDTH-lane wide words (lane 0 = first word, at LSBs)
// with a one-entry output slot and a flush path that zero-fills unfilled lanes.
module aggregator
  import aggregator_pkg::*;
#(
  parameter int DATA_WIDTH    = AGG_DATA_WIDTH,
  parameter int FETCH_WIDTH   = AGG_FETCH_WIDTH,
  parameter int COUNTER_WIDTH = $clog2(FETCH_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              flush,
  output logic                              busy
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(FETCH_WIDTH - 1);

  logic [COUNTER_WIDTH-1:0]                 idx;
  logic [FETCH_WIDTH-2:0][DATA_WIDTH-1:0]   lane_regs;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0]        out_r;
  logic                                     out_valid;

  logic drain, slot_free, last, accept, complete, flush_fire;
  logic [COUNTER_WIDTH-1:0]                 n_filled;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0]        comp_word, flush_word;

  assign drain      = out_valid & receiver_full_n;
  assign slot_free  = !out_valid | drain;
  assign last       = (idx == LAST_IDX);
  assign accept     = rst_n & sender_empty_n & (!last | slot_free);
  assign complete   = accept & last;
  // Lanes filled once this cycle's accept is counted; only meaningful when !complete.
  assign n_filled   = (accept && !last) ? idx + 1'b1 : idx;
  assign flush_fire = flush & (n_filled != '0) & !complete & slot_free;

  assign sender_deq    = accept;
  assign receiver_enq  = rst_n & drain;
  assign receiver_data = out_r;
  assign busy          = (idx != '0) | out_valid;

  // Flush word takes the word accepted this cycle at lane idx; lanes past it are zero
  // since lane_regs may hold leftovers from an earlier group.
  always_comb begin
    comp_word  = '0;
    flush_word = '0;
    for (int k = 0; k < FETCH_WIDTH - 1; k++) begin
      `LANE(comp_word, k) = lane_regs[k];
      if (k < int'(idx))
        `LANE(flush_word, k) = lane_regs[k];
      else if (accept && k == int'(idx))
        `LANE(flush_word, k) = sender_data;
    end
    `LANE(comp_word, FETCH_WIDTH - 1) = sender_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      lane_regs <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept && !last)
        lane_regs[idx] <= sender_data;

      if (complete || flush_fire)
        idx <= '0;
      else if (accept)
        idx <= idx + 1'b1;

      if (complete) begin
        out_r     <= comp_word;
        out_valid <= 1'b1;
      end else if (flush_fire) begin
        out_r     <= flush_word;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aggregator.sv
// Directed bench for aggregator: streaming, back-pressure, flush cases, reset
// mid-group, and a random-stall run checked against the 0,1,2,... input order.
module tb_aggregator;
  localparam int DW = 16;
  localparam int FW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     sender_data;
  logic              sender_empty_n;
  logic              sender_deq;
  logic [FW*DW-1:0]  receiver_data;
  logic              receiver_full_n;
  logic              receiver_enq;
  logic              flush;
  logic              busy;

  aggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .COUNTER_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .sender_data(sender_data), .sender_empty_n(sender_empty_n), .sender_deq(sender_deq),
    .receiver_data(receiver_data), .receiver_full_n(receiver_full_n), .receiver_enq(receiver_enq),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cnt = 0;
  bit feed = 0, mon = 0;
  logic [FW*DW-1:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Advance one clock; in feed mode the sender presents cnt and bumps it on each pop.
  task automatic tick();
    logic d;
    d = sender_deq;
    @(posedge clk); #1;
    if (feed && d) begin
      cnt++;
      sender_data = DW'(cnt);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    sender_empty_n = 1'b1;
    sender_data    = w;
    #1;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; feed = 0; flush = 1'b0;
    sender_empty_n = 1'b1; receiver_full_n = 1'b1; sender_data = '0;
    #1;
    chk("rst_deq", 64'(sender_deq), 64'd0);
    chk("rst_enq", 64'(receiver_enq), 64'd0);
    tick(); tick();
    rst_n = 1'b1; cnt = 0; sender_data = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(receiver_data), 64'd0);
  endtask

  always @(negedge clk)
    if (mon && receiver_enq) got_q.push_back(receiver_data);

  initial begin
    logic [63:0] exp;

    // 1: full-rate streaming
    do_reset();
    feed = 1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("t1_deq%0d", i), 64'(sender_deq), 64'd1);
      chk($sformatf("t1_enq%0d", i), 64'(receiver_enq), 64'((i == 4) || (i == 8)));
      if (i == 4) chk("t1_word0", receiver_data, 64'h0003_0002_0001_0000);
      if (i == 8) chk("t1_word1", receiver_data, 64'h0007_0006_0005_0004);
      tick();
    end

    // 2: consumer full
    do_reset();
    feed = 1; receiver_full_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("t2_deq%0d", i), 64'(sender_deq), (i < 7) ? 64'd1 : 64'd0);
      chk($sformatf("t2_enq%0d", i), 64'(receiver_enq), 64'd0);
      if (i == 8) chk("t2_hold", receiver_data, 64'h0003_0002_0001_0000);
      tick();
    end
    receiver_full_n = 1'b1;
    #1;
    chk("t2_rel_deq", 64'(sender_deq), 64'd1);
    chk("t2_rel_enq", 64'(receiver_enq), 64'd1);
    chk("t2_rel_data", receiver_data, 64'h0003_0002_0001_0000);
    tick(); #1;
    chk("t2_next_enq", 64'(receiver_enq), 64'd1);
    chk("t2_next_data", receiver_data, 64'h0007_0006_0005_0004);

    // 4: flush with sender empty
    do_reset();
    push(16'hAAAA); push(16'hBBBB);
    sender_empty_n = 1'b0; flush = 1'b1;
    #1; chk("t4_enq_now", 64'(receiver_enq), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_enq", 64'(receiver_enq), 64'd1);
    chk("t4_data", receiver_data, 64'h0000_0000_BBBB_AAAA);
    chk("t4_busy", 64'(busy), 64'd1);
    tick(); #1;
    chk("t4_busy_after", 64'(busy), 64'd0);
    chk("t4_enq_after", 64'(receiver_enq), 64'd0);

    // 5a: flush in the accept cycle; 5b: flush at idx 0
    do_reset();
    push(16'hAAAA); push(16'hBBBB);
    flush = 1'b1;
    push(16'hCCCC);
    sender_empty_n = 1'b0; flush = 1'b0;
    #1;
    chk("t5a_enq", 64'(receiver_enq), 64'd1);
    chk("t5a_data", receiver_data, 64'h0000_CCCC_BBBB_AAAA);
    tick();
    flush = 1'b1;
    #1; chk("t5b_busy", 64'(busy), 64'd0);
    tick(); flush = 1'b0;
    #1; chk("t5b_enq", 64'(receiver_enq), 64'd0);

    // 5d: flush in the completion cycle emits only the full word
    do_reset();
    push(16'h0001); push(16'h0002); push(16'h0003);
    flush = 1'b1;
    push(16'h0004);
    flush = 1'b0; sender_empty_n = 1'b0;
    #1;
    chk("t5d_data", receiver_data, 64'h0004_0003_0002_0001);
    tick(); #1;
    chk("t5d_no_extra", 64'(receiver_enq), 64'd0);
    chk("t5d_busy", 64'(busy), 64'd0);

    // 5c: flush deferred while output slot is blocked
    do_reset();
    receiver_full_n = 1'b0;
    push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
    push(16'h0005); push(16'h0006);
    sender_empty_n = 1'b0; flush = 1'b1;
    #1;
    chk("t5c_enq0", 64'(receiver_enq), 64'd0);
    chk("t5c_busy0", 64'(busy), 64'd1);
    tick(); tick();
    receiver_full_n = 1'b1;
    #1;
    chk("t5c_enq1", 64'(receiver_enq), 64'd1);
    chk("t5c_data1", receiver_data, 64'h0004_0003_0002_0001);
    tick(); flush = 1'b0;
    #1;
    chk("t5c_enq2", 64'(receiver_enq), 64'd1);
    chk("t5c_data2", receiver_data, 64'h0000_0000_0006_0005);
    tick(); #1;
    chk("t5c_idle", 64'(busy), 64'd0);

    // 6: reset mid-group
    do_reset();
    push(16'h0011); push(16'h0022);
    rst_n = 1'b0; sender_data = 16'h0099;
    #1;
    chk("t6_deq_rst", 64'(sender_deq), 64'd0);
    chk("t6_enq_rst", 64'(receiver_enq), 64'd0);
    tick(); rst_n = 1'b1;
    #1; chk("t6_busy", 64'(busy), 64'd0);
    push(16'h0031); push(16'h0032); push(16'h0033); push(16'h0034);
    sender_empty_n = 1'b0;
    #1;
    chk("t6_enq", 64'(receiver_enq), 64'd1);
    chk("t6_data", receiver_data, 64'h0034_0033_0032_0031);
    tick();

    // 3: random producer gaps and consumer stalls, order preserved
    do_reset();
    feed = 1; mon = 1;
    for (int i = 0; i < 1200; i++) begin
      sender_empty_n  = ($urandom_range(0, 3) != 0);
      receiver_full_n = ($urandom_range(0, 2) != 0);
      #1;
      tick();
    end
    sender_empty_n = 1'b0; receiver_full_n = 1'b1;
    for (int i = 0; i < 4; i++) begin #1; tick(); end
    mon = 0;
    chk("t3_count", 64'(got_q.size()), 64'(cnt / FW));
    chk("t3_busy", 64'(busy), 64'((cnt % FW) != 0));
    for (int w = 0; w < got_q.size(); w++) begin
      for (int k = 0; k < FW; k++) exp[k*DW +: DW] = DW'(w * FW + k);
      chk($sformatf("t3_word%0d", w), got_q[w], exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
